control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multicycle controller that sits directly upstream of the 36-bit datapath and drives every datapath control input.
- Consumes `op` and `zero` from the datapath. Produces register, PC, mux, ALU and memory-write strobes.
- Moore FSM with one Mealy term: the branch PC-enable, qualified by `zero`.
- Adds `halted`, `illegal` and `retire` status signals for the testbench and top level.

Parameters:
- OP_W, 6, opcode width.
- ALU_W, 3, alu_op width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from the instruction register.
- zero  in  1  ALU-result-is-zero flag, combinational from the datapath.
- ir_write  out  1  instruction-register load enable.
- pc_write  out  1  PC register enable (final, branch-qualified).
- branch  out  1  high while a branch compare is in progress.
- rf_write  out  1  register-file write enable.
- mem_to_reg  out  1  selects the write-back source: 0 = ALU register, 1 = memory-data register.
- i_or_d  out  1  memory address select: 0 = PC, 1 = imm.
- pc_src  out  1  PC next-value select: 0 = ALU result, 1 = {1'b1, imm[10:0]}.
- alu_sel_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_sel_b  out  2  ALU B select: 00 = 1, 01 = register B, 10 = sign-extended imm, 11 = 0.
- alu_op  out  3  ALU operation code.
- mem_write  out  1  memory write strobe; write data is register A.
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction.
- halted  out  1  sticky; high in HALT state.
- illegal  out  1  sticky; high when halted by an undefined opcode.

Behaviour:
- States: RST, FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_RD, LOAD_WB, MEM_WR, BR_CMP, JUMP, HALT.
- Default output in every state: all strobes 0, selects 0, alu_op = 000 (ADD), unless listed below.
- Memory read is combinational from `addr`.
- alu_op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SHL, 111 SHR.
- Opcode map:
  - 00h NOP.
  - 08h-0Fh R-type; alu_op = op[2:0].
  - 10h-17h I-type; alu_op = op[2:0].
  - 20h LOAD.
  - 21h STORE.
  - 22h BEQ.
  - 23h JMP.
  - 3Fh HALT.
  - All other opcodes are illegal.
- Reset: while reset = 0, state = RST and illegal = 0 (asynchronous). In RST all outputs are 0. The first clock edge after reset deasserts moves to FETCH.
- FETCH: ir_write = 1, alu_sel_a = 0, alu_sel_b = 00, ADD, pc_src = 0, pc_write = 1. Next state is DECODE.
- DECODE: no strobes; register A and register B latch. Next state by opcode:
  - NOP -> FETCH, with retire = 1.
  - R-type -> EXEC_R.
  - I-type -> EXEC_I.
  - LOAD -> MEM_RD.
  - STORE -> MEM_WR.
  - BEQ -> BR_CMP.
  - JMP -> JUMP.
  - HALT -> HALT.
  - Illegal -> HALT, and set illegal.
- EXEC_R: alu_sel_a = 1, alu_sel_b = 01, alu_op = op[2:0]. Next state is ALU_WB.
- EXEC_I: alu_sel_a = 1, alu_sel_b = 10, alu_op = op[2:0]. Next state is ALU_WB.
- ALU_WB: rf_write = 1, mem_to_reg = 0, retire = 1. Next state is FETCH.
- MEM_RD: i_or_d = 1; the memory-data register captures memory. Next state is LOAD_WB.
- LOAD_WB: rf_write = 1, mem_to_reg = 1, retire = 1. Next state is FETCH.
- MEM_WR: i_or_d = 1, mem_write = 1, retire = 1. Next state is FETCH.
- BR_CMP: alu_sel_a = 1, alu_sel_b = 01, SUB, branch = 1, pc_src = 1, pc_write = zero (Mealy), retire = 1. Next state is FETCH.
- JUMP: pc_src = 1, pc_write = 1, retire = 1. Next state is FETCH.
- HALT: absorbing; only reset exits. halted = 1, all strobes 0.
- Invariants:
  - At most one of ir_write / rf_write / mem_write is high in any cycle.
  - mem_write is never high when i_or_d = 0.
- Latencies in cycles, counted from the FETCH cycle:
  - NOP: 2.
  - ALU instructions: 4.
  - LOAD: 4.
  - STORE: 3.
  - BEQ: 3.
  - JMP: 3.
- Reset mid-instruction: asynchronous return to RST; outputs drop to 0 in the same cycle with no partial write. illegal and halted clear.
- Opcode is sampled only in DECODE. `op` changes in other states are ignored.
- The next-state and output decode must be full-case; an undefined state register value recovers to RST.

Test Plan:
- Reset, then release; op = 00h -> RST for 1 cycle, FETCH (ir_write = 1, pc_write = 1), DECODE, FETCH; retire pulses once in the DECODE cycle.
- op = 0Ah (R-type AND) -> sequence FETCH, DECODE, EXEC_R (alu_op = 010, alu_sel_b = 01), ALU_WB (rf_write = 1, mem_to_reg = 0); 4 cycles total.
- op = 20h then op = 21h -> LOAD: MEM_RD (i_or_d = 1, mem_write = 0), then LOAD_WB (mem_to_reg = 1, rf_write = 1). STORE: MEM_WR (i_or_d = 1, mem_write = 1), no rf_write.
- op = 22h with zero = 1, then with zero = 0 -> in BR_CMP, branch = 1, alu_op = 001, pc_src = 1; pc_write = 1 for zero = 1 and 0 for zero = 0.
- op = 3Fh, then op = 05h in a separate run -> HALT with halted = 1 and all strobes 0 for 20 cycles; the second run also sets illegal = 1. Both flags clear when reset is driven low asynchronously.
- Drive reset low during EXEC_R -> outputs go to 0 immediately (before the next clock edge), rf_write never asserts, and state restarts at RST.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle controller for the 36-bit datapath: a Moore FSM that drives every datapath
// strobe and select, plus one Mealy term (the branch PC enable, qualified by zero).
module control_fsm #(
  parameter int OP_W  = 6,
  parameter int ALU_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             zero,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             rf_write,
  output logic             mem_to_reg,
  output logic             i_or_d,
  output logic             pc_src,
  output logic             alu_sel_a,
  output logic [1:0]       alu_sel_b,
  output logic [ALU_W-1:0] alu_op,
  output logic             mem_write,
  output logic             retire,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [3:0] {
    ST_RST     = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXEC_R  = 4'd3,
    ST_EXEC_I  = 4'd4,
    ST_ALU_WB  = 4'd5,
    ST_MEM_RD  = 4'd6,
    ST_LOAD_WB = 4'd7,
    ST_MEM_WR  = 4'd8,
    ST_BR_CMP  = 4'd9,
    ST_JUMP    = 4'd10,
    ST_HALT    = 4'd11
  } state_t;

  typedef enum logic [3:0] {
    C_NOP   = 4'd0,
    C_RTYPE = 4'd1,
    C_ITYPE = 4'd2,
    C_LOAD  = 4'd3,
    C_STORE = 4'd4,
    C_BEQ   = 4'd5,
    C_JMP   = 4'd6,
    C_HALT  = 4'd7,
    C_ILL   = 4'd8
  } op_class_t;

  function automatic op_class_t classify(input logic [OP_W-1:0] o);
    op_class_t c;
    if (o == OP_W'(6'h00)) begin
      c = C_NOP;
    end else if (o[OP_W-1:3] == (OP_W-3)'(1)) begin
      c = C_RTYPE;
    end else if (o[OP_W-1:3] == (OP_W-3)'(2)) begin
      c = C_ITYPE;
    end else begin
      case (o)
        OP_W'(6'h20): c = C_LOAD;
        OP_W'(6'h21): c = C_STORE;
        OP_W'(6'h22): c = C_BEQ;
        OP_W'(6'h23): c = C_JMP;
        OP_W'(6'h3F): c = C_HALT;
        default:      c = C_ILL;
      endcase
    end
    return c;
  endfunction

  state_t           state_q, state_d;
  logic [ALU_W-1:0] alu_q, alu_d;
  logic             illegal_q, illegal_d;
  op_class_t        dec_class_s;

  assign dec_class_s = classify(op);
  assign illegal     = illegal_q;

  // State, latched ALU function and sticky illegal flag; reset returns to RST asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RST;
      alu_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and output decode; the ALU function is captured in DECODE so later op changes are ignored.
  always_comb begin
    state_d    = ST_RST;
    alu_d      = alu_q;
    illegal_d  = illegal_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    rf_write   = 1'b0;
    mem_to_reg = 1'b0;
    i_or_d     = 1'b0;
    pc_src     = 1'b0;
    alu_sel_a  = 1'b0;
    alu_sel_b  = 2'b00;
    alu_op     = '0;
    mem_write  = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        alu_d = op[ALU_W-1:0];
        case (dec_class_s)
          C_NOP: begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          C_RTYPE: state_d = ST_EXEC_R;
          C_ITYPE: state_d = ST_EXEC_I;
          C_LOAD:  state_d = ST_MEM_RD;
          C_STORE: state_d = ST_MEM_WR;
          C_BEQ:   state_d = ST_BR_CMP;
          C_JMP:   state_d = ST_JUMP;
          C_HALT:  state_d = ST_HALT;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_EXEC_R: begin
        alu_sel_a = 1'b1;
        alu_sel_b = 2'b01;
        alu_op    = alu_q;
        state_d   = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_sel_a = 1'b1;
        alu_sel_b = 2'b10;
        alu_op    = alu_q;
        state_d   = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        rf_write = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_MEM_RD: begin
        i_or_d  = 1'b1;
        state_d = ST_LOAD_WB;
      end
      ST_LOAD_WB: begin
        rf_write   = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BR_CMP: begin
        alu_sel_a = 1'b1;
        alu_sel_b = 2'b01;
        alu_op    = ALU_W'(3'b001);
        branch    = 1'b1;
        pc_src    = 1'b1;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        halted  = 1'b1;
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Randomized instruction stream checked cycle-by-cycle against an instruction-level model
// that lists the expected control vector for each cycle of each opcode class.
module tb_control_fsm;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       rf_write;
    logic       mem_to_reg;
    logic       i_or_d;
    logic       pc_src;
    logic       alu_sel_a;
    logic [1:0] alu_sel_b;
    logic [2:0] alu_op;
    logic       mem_write;
    logic       retire;
    logic       halted;
    logic       illegal;
  } out_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       ir_write, pc_write, branch, rf_write, mem_to_reg, i_or_d, pc_src, alu_sel_a;
  logic [1:0] alu_sel_b;
  logic [2:0] alu_op;
  logic       mem_write, retire, halted, illegal;
  out_t       obs;

  int checks = 0;
  int errors = 0;

  control_fsm #(.OP_W(6), .ALU_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .branch(branch), .rf_write(rf_write),
    .mem_to_reg(mem_to_reg), .i_or_d(i_or_d), .pc_src(pc_src), .alu_sel_a(alu_sel_a),
    .alu_sel_b(alu_sel_b), .alu_op(alu_op), .mem_write(mem_write), .retire(retire),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ir_write, pc_write, branch, rf_write, mem_to_reg, i_or_d, pc_src, alu_sel_a,
                alu_sel_b, alu_op, mem_write, retire, halted, illegal};

  // Instruction classes: 0 NOP, 1 R, 2 I, 3 LOAD, 4 STORE, 5 BEQ, 6 JMP, 7 HALT, 8 illegal
  function automatic int op_kind(input logic [5:0] o);
    int v = int'(o);
    if (v == 0) return 0;
    if (v >= 8 && v <= 15) return 1;
    if (v >= 16 && v <= 23) return 2;
    if (v == 32) return 3;
    if (v == 33) return 4;
    if (v == 34) return 5;
    if (v == 35) return 6;
    if (v == 63) return 7;
    return 8;
  endfunction

  function automatic int latency(input logic [5:0] o);
    case (op_kind(o))
      0: return 2;
      1, 2, 3: return 4;
      default: return 3;
    endcase
  endfunction

  // Expected controls for cycle k of an instruction (k = 0 is its FETCH cycle)
  function automatic out_t expect_out(input logic [5:0] o, input int k, input logic z);
    out_t e = '0;
    int kind = op_kind(o);
    if (k == 0) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end else if (k == 1) begin
      e.retire = (kind == 0);
    end else if (kind == 7 || kind == 8) begin
      e.halted  = 1'b1;
      e.illegal = (kind == 8);
    end else if (kind == 1 || kind == 2) begin
      if (k == 2) begin
        e.alu_sel_a = 1'b1;
        e.alu_sel_b = (kind == 1) ? 2'b01 : 2'b10;
        e.alu_op    = o[2:0];
      end else begin
        e.rf_write = 1'b1;
        e.retire   = 1'b1;
      end
    end else if (kind == 3) begin
      if (k == 2) begin
        e.i_or_d = 1'b1;
      end else begin
        e.rf_write   = 1'b1;
        e.mem_to_reg = 1'b1;
        e.retire     = 1'b1;
      end
    end else if (kind == 4) begin
      e.i_or_d    = 1'b1;
      e.mem_write = 1'b1;
      e.retire    = 1'b1;
    end else if (kind == 5) begin
      e.alu_sel_a = 1'b1;
      e.alu_sel_b = 2'b01;
      e.alu_op    = 3'b001;
      e.branch    = 1'b1;
      e.pc_src    = 1'b1;
      e.pc_write  = z;
      e.retire    = 1'b1;
    end else begin
      e.pc_src   = 1'b1;
      e.pc_write = 1'b1;
      e.retire   = 1'b1;
    end
    return e;
  endfunction

  task automatic check(input string tag, input out_t got, input out_t want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_inv(input string tag, input out_t got);
    int writes = int'(got.ir_write) + int'(got.rf_write) + int'(got.mem_write);
    checks++;
    assert (writes <= 1 && !(got.mem_write && !got.i_or_d)) else begin
      errors++;
      $error("FAIL %s invariant: got %h expected at most one write and no mem_write without i_or_d", tag, got);
    end
  endtask

  // zmode: 0/1 drive zero constant, 2 randomize; ncyc > 0 overrides the instruction length
  task automatic run_instr(input string tag, input logic [5:0] o, input int zmode, input int ncyc);
    int n = (ncyc > 0) ? ncyc : latency(o);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      op   = (k == 1) ? o : 6'($urandom);
      zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      check($sformatf("%s op=%h cyc%0d", tag, o, k), obs, expect_out(o, k, zero));
      check_inv(tag, obs);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1 check({tag, "_async"}, obs, '0);
    @(negedge clk);
    #1 check({tag, "_held"}, obs, '0);
    reset = 1'b1;
    #1 check({tag, "_rst_state"}, obs, '0);
  endtask

  function automatic logic [5:0] rand_legal_op();
    logic [2:0] r3 = 3'($urandom);
    case ($urandom_range(0, 6))
      0: return 6'h00;
      1: return {3'b001, r3};
      2: return {3'b010, r3};
      3: return 6'h20;
      4: return 6'h21;
      5: return 6'h22;
      default: return 6'h23;
    endcase
  endfunction

  logic [5:0] ill_ops [6] = '{6'h05, 6'h07, 6'h18, 6'h24, 6'h30, 6'h3E};

  initial begin
    reset = 1'b0;
    op    = 6'h00;
    zero  = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("reset", obs, '0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("release_rst_cycle", obs, '0);

    run_instr("nop", 6'h00, 0, 0);
    run_instr("rtype_and", 6'h0A, 2, 0);
    run_instr("load", 6'h20, 2, 0);
    run_instr("store", 6'h21, 2, 0);
    run_instr("beq_taken", 6'h22, 1, 0);
    run_instr("beq_not_taken", 6'h22, 0, 0);
    run_instr("jmp", 6'h23, 2, 0);
    run_instr("itype_shr", 6'h17, 2, 0);

    for (int i = 0; i < 80; i++) begin
      run_instr("random", rand_legal_op(), 2, 0);
    end

    // Reset arriving during EXEC_R must drop every strobe before the next edge
    run_instr("rtype_abort", 6'h0B, 2, 3);
    async_reset("rst_exec_r");
    run_instr("after_abort", 6'h0C, 2, 0);

    run_instr("halt", 6'h3F, 2, 22);
    async_reset("rst_halt");
    run_instr("illegal_05", 6'h05, 2, 22);
    async_reset("rst_illegal");
    run_instr("illegal_rand", ill_ops[$urandom_range(0, 5)], 2, 6);
    async_reset("rst_illegal_rand");
    run_instr("recovered", 6'h00, 2, 0);
    run_instr("recovered_ld", 6'h20, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
